baud_share_arbiter: RTL and testbench

//  Shares one high-speed baud generator (baudRGen_HS: 2-bit rate select, enable, slow clock out)

---
 rtl/uart_pkg.sv | 25 ++
 rtl/baud_hold_timer.sv | 32 +++
 rtl/baud_share_arbiter.sv | 117 +++++++++++
 tb/tb_baud_share_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART baud-generator sharing logic:
// arbiter state encoding, generator rate-select codes and requester indices.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    // 2-bit rate select of the high-speed baud generator
    localparam logic [1:0] RATE_SEL_0 = 2'd0;
    localparam logic [1:0] RATE_SEL_1 = 2'd1;
    localparam logic [1:0] RATE_SEL_2 = 2'd2;
    localparam logic [1:0] RATE_SEL_3 = 2'd3;

    localparam logic REQ_0 = 1'b0;
    localparam logic REQ_1 = 1'b1;

    function automatic logic [1:0] req_onehot(input logic idx);
        return (idx == REQ_1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/baud_hold_timer.sv
// Grant hold counter: counts cycles while enabled, flags the last allowed
// cycle when MAX_HOLD is non-zero.
module baud_hold_timer
    import uart_pkg::*;
#(
    parameter int unsigned HOLD_W   = 16,
    parameter int unsigned MAX_HOLD = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [HOLD_W-1:0] LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    logic [HOLD_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = (MAX_HOLD != 0) && en && (cnt == LAST);

endmodule

// File: rtl/baud_share_arbiter.sv
// Round-robin sharing of one baud generator between two requesters, with a
// gen_en settle window on every handover and an optional hold timeout.
module baud_share_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned MAX_HOLD   = 0,
    parameter int unsigned HOLD_W     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] rate0,
    input  logic [1:0] rate1,
    input  logic [1:0] done,
    output logic [1:0] gnt,
    output logic [1:0] gen_rate,
    output logic       gen_en,
    output logic       busy,
    output logic       tmo
);

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE_CYC - 1);

    arb_state_t state, state_nxt;
    logic       owner, owner_nxt;
    logic       rr_ptr;
    logic       pick;
    logic [3:0] settle_cnt, settle_nxt;
    logic       tmo_nxt;
    logic       hold_exp;

    baud_hold_timer #(
        .HOLD_W   (HOLD_W),
        .MAX_HOLD (MAX_HOLD)
    ) u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state != ST_ACTIVE),
        .en     (state == ST_ACTIVE),
        .expire (hold_exp)
    );

    // On a tie rr_ptr already names the requester that did not own last
    assign pick = (req == 2'b11) ? rr_ptr : req[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            owner      <= REQ_0;
            settle_cnt <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            settle_cnt <= settle_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        settle_nxt = settle_cnt;
        tmo_nxt    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    owner_nxt  = pick;
                    settle_nxt = SETTLE_M1;
                    state_nxt  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (!req[owner]) begin
                    state_nxt = ST_RELEASE;
                end else if (settle_cnt == '0) begin
                    state_nxt = ST_ACTIVE;
                end else begin
                    settle_nxt = settle_cnt - 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (done[owner] || !req[owner]) begin
                    state_nxt = ST_RELEASE;
                end else if (hold_exp) begin
                    state_nxt = ST_RELEASE;
                    tmo_nxt   = 1'b1;
                end
            end
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt      <= '0;
            gen_en   <= 1'b0;
            gen_rate <= RATE_SEL_0;
            busy     <= 1'b0;
            tmo      <= 1'b0;
            rr_ptr   <= REQ_0;
        end else begin
            gnt    <= (state_nxt == ST_ACTIVE) ? req_onehot(owner_nxt) : 2'b00;
            gen_en <= (state_nxt == ST_ACTIVE);
            busy   <= (state_nxt != ST_IDLE);
            tmo    <= tmo_nxt;
            if (state == ST_IDLE && req != 2'b00) begin
                gen_rate <= pick ? rate1 : rate0;
            end
            if (state == ST_RELEASE) begin
                rr_ptr <= ~owner;
            end
        end
    end

endmodule

// File: tb/tb_baud_share_arbiter.sv
// Scoreboard bench for baud_share_arbiter: stimulus queues expected output
// changes with their cycle stamps; a negedge monitor pops and compares them.
module tb_baud_share_arbiter;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req, rate0, rate1, done;
    logic [1:0] gnt, gen_rate;
    logic       gen_en, busy, tmo;

    baud_share_arbiter #(
        .SETTLE_CYC (2),
        .MAX_HOLD   (20),
        .HOLD_W     (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .rate0    (rate0),
        .rate1    (rate1),
        .done     (done),
        .gnt      (gnt),
        .gen_rate (gen_rate),
        .gen_en   (gen_en),
        .busy     (busy),
        .tmo      (tmo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [6:0] val;
        string      name;
    } exp_t;

    exp_t       sbq[$];
    int         tests = 0;
    int         fails = 0;
    int         base  = 0;
    logic [6:0] cur;
    logic [6:0] prev = 7'b0;
    exp_t       e;

    task automatic expect_at(input int off, input logic [1:0] g, input logic en,
                             input logic [1:0] r, input logic b, input logic t,
                             input string nm);
        exp_t x;
        x.at   = base + off;
        x.val  = {g, en, r, b, t};
        x.name = nm;
        sbq.push_back(x);
    endtask

    task automatic at(input int off);
        while (cyc < base + off) @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, want);
        end
    endtask

    // Monitor: output vector {gnt, gen_en, gen_rate, busy, tmo}
    always @(negedge clk) begin
        cur = {gnt, gen_en, gen_rate, busy, tmo};
        tests++;
        if (gnt === 2'b11 || gen_en !== (|gnt)) begin
            fails++;
            $display("FAIL invariant @cyc %0d: gnt=%b gen_en=%b", cyc, gnt, gen_en);
        end
        if (cur !== prev) begin
            tests++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_change @cyc %0d: got %b, expected no change from %b",
                         cyc, cur, prev);
            end else begin
                e = sbq.pop_front();
                if (cur !== e.val || cyc != e.at) begin
                    fails++;
                    $display("FAIL %s: got %b @cyc %0d, expected %b @cyc %0d",
                             e.name, cur, cyc, e.val, e.at);
                end
            end
            prev = cur;
        end
    end

    initial begin
        req   = 2'b00;
        rate0 = RATE_SEL_0;
        rate1 = RATE_SEL_0;
        done  = 2'b00;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt",  {6'd0, gnt},      8'd0);
        check("rst_en",   {7'd0, gen_en},   8'd0);
        check("rst_rate", {6'd0, gen_rate}, 8'd0);
        check("rst_busy", {7'd0, busy},     8'd0);
        check("rst_tmo",  {7'd0, tmo},      8'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Tie straight after reset: requester 0 first, then 1 after a 4-cycle gap
        base = cyc;
        req = 2'b11; rate0 = RATE_SEL_1; rate1 = RATE_SEL_2;
        expect_at(1,  2'b00, 0, 2'd1, 1, 0, "tie_setup0");
        expect_at(3,  2'b01, 1, 2'd1, 1, 0, "tie_gnt0");
        expect_at(6,  2'b00, 0, 2'd1, 1, 0, "tie_rel0");
        expect_at(7,  2'b00, 0, 2'd1, 0, 0, "tie_idle");
        expect_at(8,  2'b00, 0, 2'd2, 1, 0, "tie_setup1");
        expect_at(10, 2'b10, 1, 2'd2, 1, 0, "tie_gnt1");
        expect_at(13, 2'b00, 0, 2'd2, 1, 0, "tie_rel1");
        expect_at(14, 2'b00, 0, 2'd2, 0, 0, "tie_idle1");
        at(5);  done = 2'b01;
        at(6);  done = 2'b00;
        at(12); done = 2'b10; req = 2'b00;
        at(13); done = 2'b00;
        at(16);

        // Single request with done and req drop together
        base = cyc;
        req = 2'b01; rate0 = RATE_SEL_3;
        expect_at(1, 2'b00, 0, 2'd3, 1, 0, "single_setup");
        expect_at(3, 2'b01, 1, 2'd3, 1, 0, "single_gnt");
        expect_at(6, 2'b00, 0, 2'd3, 1, 0, "single_rel");
        expect_at(7, 2'b00, 0, 2'd3, 0, 0, "single_idle");
        at(5); done = 2'b01; req = 2'b00;
        at(6); done = 2'b00;
        at(9);

        // Abort during SETUP: no grant, busy drops after RELEASE
        base = cyc;
        req = 2'b01; rate0 = RATE_SEL_2;
        expect_at(1, 2'b00, 0, 2'd2, 1, 0, "abort_setup");
        expect_at(3, 2'b00, 0, 2'd2, 0, 0, "abort_idle");
        at(1); req = 2'b00;
        at(5);

        // Rate change while ACTIVE must not reach gen_rate
        base = cyc;
        req = 2'b01; rate0 = RATE_SEL_1;
        expect_at(1, 2'b00, 0, 2'd1, 1, 0, "rate_setup");
        expect_at(3, 2'b01, 1, 2'd1, 1, 0, "rate_gnt");
        expect_at(7, 2'b00, 0, 2'd1, 1, 0, "rate_rel");
        expect_at(8, 2'b00, 0, 2'd1, 0, 0, "rate_idle");
        at(4);  rate0 = RATE_SEL_3;
        at(6);  done = 2'b01; req = 2'b00;
        at(7);  done = 2'b00;
        at(10);

        // Non-owner done/req noise is ignored
        base = cyc;
        req = 2'b01; rate0 = RATE_SEL_0;
        expect_at(1,  2'b00, 0, 2'd0, 1, 0, "noise_setup");
        expect_at(3,  2'b01, 1, 2'd0, 1, 0, "noise_gnt");
        expect_at(10, 2'b00, 0, 2'd0, 1, 0, "noise_rel");
        expect_at(11, 2'b00, 0, 2'd0, 0, 0, "noise_idle");
        at(4);  done = 2'b10; req = 2'b11;
        at(5);  done = 2'b00; req = 2'b01;
        at(6);  req = 2'b11;
        at(7);  req = 2'b01; done = 2'b10;
        at(8);  done = 2'b00;
        at(9);  done = 2'b01; req = 2'b00;
        at(10); done = 2'b00;
        at(13);

        // Hold timeout: 20 grant cycles, tmo pulse, re-arbitration, then reset mid-ACTIVE
        base = cyc;
        req = 2'b10; rate1 = RATE_SEL_3;
        expect_at(1,  2'b00, 0, 2'd3, 1, 0, "tmo_setup");
        expect_at(3,  2'b10, 1, 2'd3, 1, 0, "tmo_gnt");
        expect_at(23, 2'b00, 0, 2'd3, 1, 1, "tmo_pulse");
        expect_at(24, 2'b00, 0, 2'd3, 0, 0, "tmo_idle");
        expect_at(25, 2'b00, 0, 2'd3, 1, 0, "tmo_resetup");
        expect_at(27, 2'b10, 1, 2'd3, 1, 0, "tmo_regnt");
        expect_at(30, 2'b00, 0, 2'd0, 0, 0, "rst_mid_active");
        at(29);
        #2 rst_n = 1'b0; req = 2'b00;
        #1;
        check("async_gnt",  {6'd0, gnt},      8'd0);
        check("async_en",   {7'd0, gen_en},   8'd0);
        check("async_rate", {6'd0, gen_rate}, 8'd0);
        check("async_tmo",  {7'd0, tmo},      8'd0);
        #9 rst_n = 1'b1;
        at(34);
        check("post_rst_busy", {7'd0, busy}, 8'd0);
        check("post_rst_gnt",  {6'd0, gnt},  8'd0);

        repeat (3) @(negedge clk);
        check("sb_drained", 8'(sbq.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
